// File: rtl/onehot_decoder_seq_pkg.sv
// Shared types and helpers for the sequenced one-hot decoder and its FIFO.
package decoder_pkg;

  localparam int unsigned DEF_CODE_W = 3;
  localparam int unsigned MAX_CODE_W = 8;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  // Widest supported one-hot word; callers narrow the result with a cast.
  function automatic logic [(1 << MAX_CODE_W)-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
    logic [(1 << MAX_CODE_W)-1:0] r;
    r       = '0;
    r[code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_decoder_seq_fifo.sv
// Synchronous DEPTH x W code FIFO with occupancy counter; no push/pop bypass.
module code_fifo
  import decoder_pkg::*;
#(
  parameter int unsigned W     = DEF_CODE_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Queues binary codes and shows each as a registered one-hot word for DWELL cycles.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int unsigned CODE_W = DEF_CODE_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DWELL  = 4,
  localparam int unsigned OUT_W = 1 << CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [OUT_W-1:0]  y,
  output logic              y_valid,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DWELL) + 1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [OUT_W-1:0]    r_y;
  logic [OUT_W-1:0]    w_y_nxt;
  logic                r_y_valid;
  logic                w_y_valid_nxt;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [CODE_W-1:0]   w_head;
  logic [OUT_W-1:0]    w_head_onehot;

  assign in_ready      = ~w_full & ~rst;
  assign w_push        = in_valid & in_ready;
  assign w_head_onehot = OUT_W'(onehot(MAX_CODE_W'(w_head)));

  code_fifo #(
    .W     (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (in_code),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_y       <= w_y_nxt;
      r_y_valid <= w_y_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_y_nxt       = r_y;
    w_y_valid_nxt = r_y_valid;
    w_pop         = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_y_nxt       = '0;
        w_y_valid_nxt = 1'b0;
        if (en && !w_empty) begin
          w_pop         = 1'b1;
          w_y_nxt       = w_head_onehot;
          w_y_valid_nxt = 1'b1;
          w_cnt_nxt     = CNT_W'(DWELL - 1);
          w_state_nxt   = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          w_y_nxt       = '0;
          w_y_valid_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (!w_empty) begin
          // Reload straight from the head so consecutive words have no gap cycle.
          w_pop         = 1'b1;
          w_y_nxt       = w_head_onehot;
          w_y_valid_nxt = 1'b1;
          w_cnt_nxt     = CNT_W'(DWELL - 1);
        end else begin
          w_y_nxt       = '0;
          w_y_valid_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_y_nxt       = '0;
        w_y_valid_nxt = 1'b0;
      end
    endcase
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign busy    = (r_state == SHOW) | ~w_empty;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Directed bench for onehot_decoder_seq: DWELL=4 main instance plus a DWELL=1 instance.
module tb_onehot_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready, y_valid, busy;
  logic [7:0] y;
  logic       d1_in_ready, d1_y_valid, d1_busy;
  logic [7:0] d1_y;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  onehot_decoder_seq #(.CODE_W(3), .DEPTH(4), .DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .y_valid(y_valid), .busy(busy)
  );

  onehot_decoder_seq #(.CODE_W(3), .DEPTH(4), .DWELL(1)) u_dut_d1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(d1_in_ready), .y(d1_y), .y_valid(d1_y_valid), .busy(d1_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] exp_y, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      check({tag, "_y"}, 32'(y), 32'(exp_y));
      check({tag, "_yv"}, 32'(y_valid), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = '0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] exp2 [14];
  logic [7:0] exp6 [8];

  initial begin
    exp2 = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80,
             8'h20, 8'h20, 8'h20, 8'h20, 8'h00};
    exp6 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Reset state
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = '0;
    step(); step();
    check("rst_y", 32'(y), 32'h0);
    check("rst_yv", 32'(y_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);

    // 1: single code 3
    en = 1'b1; in_valid = 1'b1; in_code = 3'd3;
    step();
    in_valid = 1'b0;
    check("t1_k_y", 32'(y), 32'h0);
    check("t1_k_busy", 32'(busy), 32'h1);
    expect_word("t1", 8'h08, 4);
    step();
    check("t1_end_y", 32'(y), 32'h0);
    check("t1_end_yv", 32'(y_valid), 32'h0);
    check("t1_end_busy", 32'(busy), 32'h0);

    // 2: back-to-back words 0,7,5
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 3) begin
        in_valid = 1'b1;
        in_code  = (c == 0) ? 3'd0 : (c == 1) ? 3'd7 : 3'd5;
        #1;
        check("t2_ready", 32'(in_ready), 32'h1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      check("t2_y", 32'(y), 32'(exp2[c]));
      check("t2_yv", 32'(y_valid), (exp2[c] != 8'h00) ? 32'h1 : 32'h0);
    end

    // 3: fill while disabled, fifth code stalls
    do_reset();
    en = 1'b0; in_valid = 1'b1;
    in_code = 3'd1; step();
    in_code = 3'd2; step();
    in_code = 3'd4; step();
    in_code = 3'd6; step();
    check("t3_full_ready", 32'(in_ready), 32'h0);
    in_code = 3'd3; step();
    check("t3_stall_ready", 32'(in_ready), 32'h0);
    check("t3_stall_y", 32'(y), 32'h0);
    check("t3_stall_yv", 32'(y_valid), 32'h0);
    check("t3_stall_busy", 32'(busy), 32'h1);
    en = 1'b1;
    step();
    check("t3_e1_y", 32'(y), 32'h02);
    check("t3_e1_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check("t3_e2_y", 32'(y), 32'h02);
    expect_word("t3_w1t", 8'h02, 2);
    expect_word("t3_w2", 8'h04, 4);
    expect_word("t3_w3", 8'h10, 4);
    expect_word("t3_w4", 8'h40, 4);
    expect_word("t3_w5", 8'h08, 4);
    step();
    check("t3_end_y", 32'(y), 32'h0);
    check("t3_end_busy", 32'(busy), 32'h0);

    // 4: abort word 6 on its second cycle
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    in_code = 3'd6; step();
    in_code = 3'd2; step();
    in_valid = 1'b0;
    check("t4_c1_y", 32'(y), 32'h40);
    step();
    check("t4_c2_y", 32'(y), 32'h40);
    en = 1'b0;
    step();
    check("t4_abort_y", 32'(y), 32'h0);
    check("t4_abort_yv", 32'(y_valid), 32'h0);
    check("t4_abort_busy", 32'(busy), 32'h1);
    step();
    check("t4_hold_y", 32'(y), 32'h0);
    en = 1'b1;
    expect_word("t4_next", 8'h04, 4);
    step();
    check("t4_end_y", 32'(y), 32'h0);
    check("t4_end_busy", 32'(busy), 32'h0);

    // 5: reset during SHOW with three codes queued
    do_reset();
    en = 1'b1; in_valid = 1'b1;
    in_code = 3'd1; step();
    in_code = 3'd2; step();
    in_code = 3'd3; step();
    in_code = 3'd4; step();
    in_valid = 1'b0;
    check("t5_pre_y", 32'(y), 32'h02);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(in_ready), 32'h0);
    step();
    check("t5_rst_y", 32'(y), 32'h0);
    check("t5_rst_yv", 32'(y_valid), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_after_y", 32'(y), 32'h0);
      check("t5_after_busy", 32'(busy), 32'h0);
    end

    // 6: DWELL=1 streaming walk
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_code  = 3'(i);
        #1;
        check("t6_ready", 32'(d1_in_ready), 32'h1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        check("t6_y", 32'(d1_y), 32'(exp6[i-1]));
        check("t6_yv", 32'(d1_y_valid), 32'h1);
      end
    end
    step();
    check("t6_end_y", 32'(d1_y), 32'h0);
    check("t6_end_yv", 32'(d1_y_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
